hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core. Sits beside the decode stage.
- Tracks in-flight register writers in a 3-deep scoreboard (EX, MEM, WB) and detects RAW hazards for the instruction in ID.
- Sequences stalls, bubbles and branch flushes, and issues registered forwarding selects to the EX operand muxes.

Parameters:
- REG_AW, 5, register-address width.
- STALL_CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  source register 1 (instr[25:21]).
- id_rt  in  REG_AW  source register 2 (instr[20:16]).
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_dst  in  REG_AW  destination after regdst mux.
- id_reg_write  in  1  instruction writes the register file.
- id_mem_read  in  1  instruction is a load.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- pc_hold  out  1  freeze PC.
- ifid_hold  out  1  freeze the IF/ID register.
- ifid_flush  out  1  clear the IF/ID register to NOP.
- idex_bubble  out  1  load NOP into ID/EX.
- fwd_a  out  2  EX operand A select (registered).
- fwd_b  out  2  EX operand B select (registered).
- stall_cnt  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- Reset: all outputs 0; scoreboard entries invalid; FSM to HOLD. Reset asserted mid-stall or mid-flush aborts the sequence immediately.
- Scoreboard:
  - Each entry holds {valid, dst, is_load}.
  - Every non-held cycle shifts ID→EX→MEM→WB.
  - ID enters EX as valid only if id_valid && id_reg_write && id_dst!=0 && !idex_bubble.
  - Register 0 never matches.
- match(s, r): entry s valid, dst==r, and the corresponding use bit is set.
- Load-use: EX entry is_load and matches rs or rt → 1 stall cycle. pc_hold=ifid_hold=idex_bubble=1.
- Forward selects, computed in ID and registered with ID/EX:
  - 01 = from MEM: the EX entry matches.
  - 10 = from WB: the MEM entry matches.
  - 00 = register file: otherwise. A WB-entry match needs no forward because the register file bypasses same-cycle writes.
  - The EX match has priority over the MEM match.
  - Selects are forced to 00 when a bubble is inserted.
- FSM states:
  - HOLD: first cycle after reset; pc_hold=ifid_hold=1; → RUN.
  - RUN: normal issue. Load-use → STALL. ex_branch_taken → FLUSH.
  - STALL: outputs as load-use; → RUN next cycle. ex_branch_taken during STALL → FLUSH, and the stall is dropped.
  - FLUSH: asserted in the cycle ex_branch_taken is seen, driven combinationally from the input. ifid_flush=idex_bubble=1, pc_hold=0. → RUN next cycle.
- Priority: flush > stall > run. Simultaneous branch and load-use gives flush only.
- stall_cnt: +1 each cycle pc_hold=1 outside HOLD; saturates at all-ones, no wrap.
- Latency: hazard detection is combinational in ID; fwd_a/fwd_b are valid the cycle the consumer is in EX.

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- Defined: forwarding as above; only load-use stalls.
- Undefined:
  - fwd_a/fwd_b are tied to 00.
  - Stall while any EX or MEM entry matches (WB is covered by the register-file bypass). Up to 2 stall cycles per dependency.
  - STALL stays until no match remains.

Decomposition:
- Shared package mips_pkg holds:
  - Localparams FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - State encoding HZ_HOLD, HZ_RUN, HZ_STALL, HZ_FLUSH.
  - REG_AW default.
- Sub-module hazard_scoreboard: shift register plus match logic, exposing ex/mem/wb match bits for rs and rt.

Test Plan:
- Reset release → one HOLD cycle with pc_hold=1, then pc_hold=0 and stall_cnt=0.
- add $3←$1,$2, then sub $4←$3,$5 → no stall; fwd_a=01 in sub's EX cycle. One NOP between them → fwd_a=10.
- lw $3, then add $4←$3,$3 → exactly one cycle of pc_hold=ifid_hold=idex_bubble=1; then fwd_a=fwd_b=10; stall_cnt=1.
- Writer with dst $0 followed by a reader of $0 → no stall, fwd=00.
- ex_branch_taken in the same cycle as a load-use → ifid_flush=idex_bubble=1, pc_hold=0; no stall cycle follows.
- Without HAZARD_FORWARD_EN: add $3, then use $3 → 2 stall cycles; fwd stays 00. Drive a further hazard-producing stream until stall_cnt saturates at 0xFFFF and holds.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: forward-select codes,
// hazard FSM state encoding and the default register-address width.
package mips_pkg;

  localparam int DEFAULT_REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    HZ_HOLD  = 2'd0,
    HZ_RUN   = 2'd1,
    HZ_STALL = 2'd2,
    HZ_FLUSH = 2'd3
  } hz_state_e;

  // The youngest producer wins: an EX-stage writer shadows an older MEM-stage one.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit) begin
      return FWD_MEM;
    end
    if (mem_hit) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry shift register of in-flight register writers (index 0=EX, 1=MEM,
// 2=WB) with per-stage RAW match bits for the two ID source operands.
module hazard_scoreboard
  import mips_pkg::*;
#(
  parameter int REG_AW = DEFAULT_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en_i,
  input  logic              push_valid_i,
  input  logic              push_load_i,
  input  logic [REG_AW-1:0] push_dst_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              use_rs_i,
  input  logic              use_rt_i,
  output logic [2:0]        hit_rs_o,
  output logic [2:0]        hit_rt_o,
  output logic              ex_is_load_o
);

  logic [2:0]        valid_q;
  logic [2:0]        load_q;
  logic [REG_AW-1:0] dst_q [3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      load_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        dst_q[i] <= '0;
      end
    end else if (shift_en_i) begin
      valid_q  <= {valid_q[1:0], push_valid_i};
      load_q   <= {load_q[1:0], push_valid_i & push_load_i};
      dst_q[0] <= push_dst_i;
      dst_q[1] <= dst_q[0];
      dst_q[2] <= dst_q[1];
    end
  end

  // $0 is hard-wired, so a reader of $0 never depends on anything in flight.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_match
      assign hit_rs_o[gi] = valid_q[gi] && use_rs_i && (rs_i != '0) && (dst_q[gi] == rs_i);
      assign hit_rt_o[gi] = valid_q[gi] && use_rt_i && (rt_i != '0) && (dst_q[gi] == rt_i);
    end
  endgenerate

  assign ex_is_load_o = load_q[0];

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: RAW stalls, branch flushes and registered EX
// forward selects. Define HAZARD_FORWARD_EN for forwarding; otherwise stall-only.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_AW      = DEFAULT_REG_AW,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_AW-1:0]      id_rs,
  input  logic [REG_AW-1:0]      id_rt,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic [REG_AW-1:0]      id_dst,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   ex_branch_taken,
  output logic                   pc_hold,
  output logic                   ifid_hold,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  hz_state_e              state_q, state_d;
  logic [2:0]             hit_rs, hit_rt;
  logic                   ex_is_load;
  logic                   raw_hazard;
  logic                   push_valid;
  logic                   pc_hold_c, ifid_hold_c, ifid_flush_c, idex_bubble_c;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign push_valid = id_valid && id_reg_write && (id_dst != '0) && !idex_bubble_c;

  hazard_scoreboard #(
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .shift_en_i   (state_q != HZ_HOLD),
    .push_valid_i (push_valid),
    .push_load_i  (id_mem_read),
    .push_dst_i   (id_dst),
    .rs_i         (id_rs),
    .rt_i         (id_rt),
    .use_rs_i     (id_valid && id_use_rs),
    .use_rt_i     (id_valid && id_use_rt),
    .hit_rs_o     (hit_rs),
    .hit_rt_o     (hit_rt),
    .ex_is_load_o (ex_is_load)
  );

`ifdef HAZARD_FORWARD_EN
  logic [1:0] fwd_a_q, fwd_b_q;
  logic       unused_wb_hits;

  assign raw_hazard     = ex_is_load && (hit_rs[0] || hit_rt[0]);
  assign unused_wb_hits = hit_rs[2] | hit_rt[2];

  // Selects travel with the instruction into ID/EX; a bubble carries no operands.
  always_ff @(posedge clk) begin
    if (!rst_n || idex_bubble_c) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_sel(hit_rs[0], hit_rs[1]);
      fwd_b_q <= fwd_sel(hit_rt[0], hit_rt[1]);
    end
  end

  assign fwd_a = rst_n ? fwd_a_q : FWD_RF;
  assign fwd_b = rst_n ? fwd_b_q : FWD_RF;
`else
  logic unused_sb;

  // The WB producer is covered by the register-file write-through.
  assign raw_hazard = (|hit_rs[1:0]) || (|hit_rt[1:0]);
  assign unused_sb  = hit_rs[2] | hit_rt[2] | ex_is_load;
  assign fwd_a      = FWD_RF;
  assign fwd_b      = FWD_RF;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HZ_HOLD;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == HZ_HOLD) begin
      state_d = HZ_RUN;
    end else if (ex_branch_taken) begin
      state_d = HZ_FLUSH;
    end else if (raw_hazard) begin
      state_d = HZ_STALL;
    end else begin
      state_d = HZ_RUN;
    end
  end

  // Flush and stall act in the cycle their cause is seen; the state register
  // records what was done so the next cycle re-evaluates from fresh inputs.
  always_comb begin
    pc_hold_c     = 1'b0;
    ifid_hold_c   = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    if (!rst_n) begin
      pc_hold_c = 1'b0;
    end else if (state_q == HZ_HOLD) begin
      pc_hold_c   = 1'b1;
      ifid_hold_c = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
    end else if (raw_hazard) begin
      pc_hold_c     = 1'b1;
      ifid_hold_c   = 1'b1;
      idex_bubble_c = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_hold_c && (state_q != HZ_HOLD) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign pc_hold     = pc_hold_c;
  assign ifid_hold   = ifid_hold_c;
  assign ifid_flush  = ifid_flush_c;
  assign idex_bubble = idex_bubble_c;
  assign stall_cnt   = rst_n ? stall_cnt_q : '0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each driven cycle pushes its hand-computed
// expected outputs; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 8;
  localparam int K_RUN = 0, K_HOLD = 1, K_STALL = 2, K_FLUSH = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_dst = '0;
  logic          id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic          id_reg_write = 1'b0, id_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic          pc_hold, ifid_hold, ifid_flush, idex_bubble;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_AW      (AW),
    .STALL_CNT_W (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_dst          (id_dst),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .pc_hold         (pc_hold),
    .ifid_hold       (ifid_hold),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_cnt       (stall_cnt)
  );

  // ctl = {pc_hold, ifid_hold, ifid_flush, idex_bubble}
  typedef struct packed {
    logic [3:0]    ctl;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cnt_model = 0;

  task automatic step(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic urs, input logic urt, input logic [AW-1:0] dst,
                      input logic rw, input logic mr, input logic br,
                      input int kind, input logic [1:0] fa, input logic [1:0] fb,
                      input string nm);
    exp_t e;
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dst = dst; id_reg_write = rw; id_mem_read = mr; ex_branch_taken = br;
    case (kind)
      K_HOLD:  e.ctl = 4'b1100;
      K_STALL: e.ctl = 4'b1101;
      K_FLUSH: e.ctl = 4'b0011;
      default: e.ctl = 4'b0000;
    endcase
    e.fa  = fa;
    e.fb  = fb;
    e.cnt = CW'(cnt_model);
    if (!rst_n) begin
      e = '0;
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      cnt_model = 0;
    end else if (kind == K_STALL && cnt_model < CNT_MAX) begin
      cnt_model = cnt_model + 1;
    end
  endtask

  task automatic nop(input int kind, input logic [1:0] fa, input logic [1:0] fb, input string nm);
    step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, kind, fa, fb, nm);
  endtask

  // Monitor: one comparison per cycle that has a pending expectation.
  initial begin
    exp_t  e;
    exp_t  act;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act.ctl = {pc_hold, ifid_hold, ifid_flush, idex_bubble};
        act.fa  = fwd_a;
        act.fb  = fwd_b;
        act.cnt = stall_cnt;
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got ctl=%b fwd_a=%b fwd_b=%b stall_cnt=%0d, expected ctl=%b fwd_a=%b fwd_b=%b stall_cnt=%0d",
                   nm, act.ctl, act.fa, act.fb, act.cnt, e.ctl, e.fa, e.fb, e.cnt);
        end else begin
          $display("ok   %s: ctl=%b fwd_a=%b fwd_b=%b stall_cnt=%0d", nm, act.ctl, act.fa, act.fb, act.cnt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    nop(K_RUN, 2'b00, 2'b00, "in_reset");
    rst_n = 1'b1;
    nop(K_HOLD, 2'b00, 2'b00, "hold_after_reset");
    nop(K_RUN, 2'b00, 2'b00, "run_after_hold");

    // add $3 <- $1,$2 followed by sub $4 <- $3,$5
    step(1, 1, 2, 1, 1, 3, 1, 0, 0, K_RUN, 2'b00, 2'b00, "add_r3");
`ifdef HAZARD_FORWARD_EN
    step(1, 3, 5, 1, 1, 4, 1, 0, 0, K_RUN, 2'b00, 2'b00, "sub_r3_id");
    nop(K_RUN, 2'b01, 2'b00, "sub_ex_fwd_mem");
    step(1, 1, 2, 1, 1, 3, 1, 0, 0, K_RUN, 2'b00, 2'b00, "add_r3_b");
    nop(K_RUN, 2'b00, 2'b00, "gap_nop");
    step(1, 3, 5, 1, 1, 4, 1, 0, 0, K_RUN, 2'b00, 2'b00, "sub_r3_id_b");
    nop(K_RUN, 2'b10, 2'b00, "sub_ex_fwd_wb");
`else
    step(1, 3, 5, 1, 1, 4, 1, 0, 0, K_STALL, 2'b00, 2'b00, "sub_stall_ex");
    step(1, 3, 5, 1, 1, 4, 1, 0, 0, K_STALL, 2'b00, 2'b00, "sub_stall_mem");
    step(1, 3, 5, 1, 1, 4, 1, 0, 0, K_RUN, 2'b00, 2'b00, "sub_issue");
    nop(K_RUN, 2'b00, 2'b00, "sub_ex");
`endif

    // lw $3 then add $4 <- $3,$3
    step(1, 1, 0, 1, 0, 3, 1, 1, 0, K_RUN, 2'b00, 2'b00, "lw_r3");
`ifdef HAZARD_FORWARD_EN
    step(1, 3, 3, 1, 1, 4, 1, 0, 0, K_STALL, 2'b00, 2'b00, "loaduse_stall");
    step(1, 3, 3, 1, 1, 4, 1, 0, 0, K_RUN, 2'b00, 2'b00, "loaduse_issue");
    nop(K_RUN, 2'b10, 2'b10, "loaduse_fwd_wb");
`else
    step(1, 3, 3, 1, 1, 4, 1, 0, 0, K_STALL, 2'b00, 2'b00, "loaduse_stall_ex");
    step(1, 3, 3, 1, 1, 4, 1, 0, 0, K_STALL, 2'b00, 2'b00, "loaduse_stall_mem");
    step(1, 3, 3, 1, 1, 4, 1, 0, 0, K_RUN, 2'b00, 2'b00, "loaduse_issue");
    nop(K_RUN, 2'b00, 2'b00, "loaduse_ex");
`endif

    // writer of $0 then reader of $0
    step(1, 1, 2, 1, 1, 0, 1, 0, 0, K_RUN, 2'b00, 2'b00, "wr_r0");
    step(1, 0, 0, 1, 1, 5, 1, 0, 0, K_RUN, 2'b00, 2'b00, "rd_r0");
    nop(K_RUN, 2'b00, 2'b00, "rd_r0_ex");

    // branch taken in the same cycle as a load-use; flushed writer of $7 must not enter
    step(1, 1, 0, 1, 0, 6, 1, 1, 0, K_RUN, 2'b00, 2'b00, "lw_r6");
    step(1, 6, 0, 1, 0, 7, 1, 0, 1, K_FLUSH, 2'b00, 2'b00, "branch_and_loaduse");
    step(1, 7, 0, 1, 0, 0, 0, 0, 0, K_RUN, 2'b00, 2'b00, "rd_r7_after_flush");
    nop(K_RUN, 2'b00, 2'b00, "after_flush");

    // branch arriving while a stall is in progress
    step(1, 1, 0, 1, 0, 8, 1, 1, 0, K_RUN, 2'b00, 2'b00, "lw_r8");
    step(1, 8, 0, 1, 0, 9, 1, 0, 0, K_STALL, 2'b00, 2'b00, "r8_stall");
    step(1, 8, 0, 1, 0, 9, 1, 0, 1, K_FLUSH, 2'b00, 2'b00, "branch_during_stall");
    nop(K_RUN, 2'b00, 2'b00, "after_flush_2");

    // reset in the middle of a stall clears counter and scoreboard
    step(1, 1, 0, 1, 0, 10, 1, 1, 0, K_RUN, 2'b00, 2'b00, "lw_r10");
    step(1, 10, 0, 1, 0, 11, 1, 0, 0, K_STALL, 2'b00, 2'b00, "r10_stall");
    rst_n = 1'b0;
    step(1, 10, 0, 1, 0, 11, 1, 0, 0, K_RUN, 2'b00, 2'b00, "reset_mid_stall");
    rst_n = 1'b1;
    step(1, 10, 0, 1, 0, 11, 1, 0, 0, K_HOLD, 2'b00, 2'b00, "hold_after_reset_2");
    step(1, 10, 0, 1, 0, 11, 1, 0, 0, K_RUN, 2'b00, 2'b00, "r10_after_reset");
    nop(K_RUN, 2'b00, 2'b00, "settle");

    // self-dependent stream ($3 <- $3) to drive the counter into saturation
`ifdef HAZARD_FORWARD_EN
    step(1, 3, 0, 1, 0, 3, 1, 1, 0, K_RUN, 2'b00, 2'b00, "sat_first");
    for (int i = 0; i < 300; i++) begin
      step(1, 3, 0, 1, 0, 3, 1, 1, 0, K_STALL, (i == 0) ? 2'b00 : 2'b10, 2'b00, "sat_stall");
      step(1, 3, 0, 1, 0, 3, 1, 1, 0, K_RUN, 2'b00, 2'b00, "sat_issue");
    end
`else
    step(1, 3, 0, 1, 0, 3, 1, 0, 0, K_RUN, 2'b00, 2'b00, "sat_first");
    for (int i = 0; i < 140; i++) begin
      step(1, 3, 0, 1, 0, 3, 1, 0, 0, K_STALL, 2'b00, 2'b00, "sat_stall_ex");
      step(1, 3, 0, 1, 0, 3, 1, 0, 0, K_STALL, 2'b00, 2'b00, "sat_stall_mem");
      step(1, 3, 0, 1, 0, 3, 1, 0, 0, K_RUN, 2'b00, 2'b00, "sat_issue");
    end
`endif
    nop(K_RUN, 2'b00, 2'b00, "sat_held");
    nop(K_RUN, 2'b00, 2'b00, "sat_held_2");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
